clk_div_gen: RTL and testbench

- Parametrised successor to the team's fixed clock divider: free-running divide counter plus a CPU clock generator with four run modes (fast, slow, single-step, hold).
- Mode switching is glitch-free.
- Single-step input is synchronised and debounced.
- A CPU-edge strobe and a cycle counter are provided for the display/debug path.
- Sits between the board oscillator and the SCPU clock input; clk_cpu is a registered signal, never gated.

---
 rtl/clk_div_gen.sv | 192 +++++++++++++++++++
 tb/tb_clk_div_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: free-running divide counter plus CPU clock generator.
//
// Run modes (i_mode / o_mode_cur): 00 FAST, 01 SLOW, 10 STEP, 11 HOLD.
// clk_cpu is a plain register output, never a gated clock.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous, active-low reset
//   i_mode       requested run mode
//   i_step       raw step button (asynchronous)
//   o_clkdiv     free-running divide counter
//   o_clk_cpu    registered CPU clock
//   o_cpu_edge   1-clk strobe in the cycle o_clk_cpu goes 0->1
//   o_cpu_cycles count of o_clk_cpu rising edges
//   o_mode_cur   mode currently driving o_clk_cpu
//   o_switching  mode change pending
module clk_div_gen #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FAST_TAP = 2,
    parameter int unsigned SLOW_TAP = 24,
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned STEP_HI  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_clkdiv,
    output logic             o_clk_cpu,
    output logic             o_cpu_edge,
    output logic [WIDTH-1:0] o_cpu_cycles,
    output logic [1:0]       o_mode_cur,
    output logic             o_switching
);

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned STEP_W = $clog2(STEP_HI + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_HI - 1);

    typedef enum logic {StIdle, StPend} state_e;

    // Divider and CPU clock
    logic [WIDTH-1:0] r_clkdiv;
    logic             r_clk_cpu;
    logic             r_cpu_edge;
    logic [WIDTH-1:0] r_cpu_cycles;

    // Switch FSM
    state_e     r_state, w_state_d;
    logic [1:0] r_tgt, w_tgt_d;
    logic [1:0] r_mode_cur, w_mode_cur_d;
    logic       r_switching, w_switching_d;

    // Step path
    logic              r_sync1, r_sync2;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_step_stb;
    logic              r_step_hi;
    logic [STEP_W-1:0] r_step_cnt;

    logic w_src_cur, w_src_tgt, w_cpu_rise;
    logic w_stb_change, w_step_accept;

    function automatic logic src_of(input logic [1:0] m, input logic fast, input logic slow,
                                    input logic step_hi);
        logic s;
        s = 1'b0;
        case (m)
            MODE_FAST: s = fast;
            MODE_SLOW: s = slow;
            MODE_STEP: s = step_hi;
            default:   s = 1'b0;
        endcase
        return s;
    endfunction

    always_comb begin
        w_src_cur = src_of(r_mode_cur, r_clkdiv[FAST_TAP], r_clkdiv[SLOW_TAP], r_step_hi);
        w_src_tgt = src_of(r_tgt, r_clkdiv[FAST_TAP], r_clkdiv[SLOW_TAP], r_step_hi);
        w_cpu_rise = ~r_clk_cpu & w_src_cur;
    end

    // Debounced level flips once the synchronised input has differed for DEB_CYC clks.
    always_comb begin
        w_stb_change  = (r_sync2 != r_step_stb) && (r_deb_cnt == DEB_LAST);
        w_step_accept = w_stb_change && r_sync2 && (r_mode_cur == MODE_STEP) &&
                        !r_switching && !r_step_hi;
    end

    // Switch only while clk_cpu and the new source are both low, so neither the
    // current phase nor the first phase of the new source gets truncated.
    always_comb begin
        w_state_d     = r_state;
        w_tgt_d       = r_tgt;
        w_mode_cur_d  = r_mode_cur;
        w_switching_d = r_switching;
        case (r_state)
            StIdle: begin
                if (i_mode != r_mode_cur) begin
                    w_tgt_d       = i_mode;
                    w_switching_d = 1'b1;
                    w_state_d     = StPend;
                end
            end
            StPend: begin
                if (i_mode == r_mode_cur) begin
                    w_switching_d = 1'b0;
                    w_state_d     = StIdle;
                end else if (!r_clk_cpu && !w_src_tgt) begin
                    w_mode_cur_d  = r_tgt;
                    w_switching_d = 1'b0;
                    w_state_d     = StIdle;
                end else begin
                    w_tgt_d = i_mode;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clkdiv     <= '0;
            r_clk_cpu    <= 1'b0;
            r_cpu_edge   <= 1'b0;
            r_cpu_cycles <= '0;
            r_state      <= StIdle;
            r_tgt        <= MODE_FAST;
            r_mode_cur   <= MODE_FAST;
            r_switching  <= 1'b0;
        end else begin
            r_clkdiv   <= r_clkdiv + WIDTH'(1);
            r_clk_cpu  <= w_src_cur;
            r_cpu_edge <= w_cpu_rise;
            if (w_cpu_rise) begin
                r_cpu_cycles <= r_cpu_cycles + WIDTH'(1);
            end
            r_state     <= w_state_d;
            r_tgt       <= w_tgt_d;
            r_mode_cur  <= w_mode_cur_d;
            r_switching <= w_switching_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb_cnt  <= '0;
            r_step_stb <= 1'b0;
            r_step_hi  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_sync1 <= i_step;
            r_sync2 <= r_sync1;

            if (r_sync2 == r_step_stb) begin
                r_deb_cnt <= '0;
            end else if (w_stb_change) begin
                r_deb_cnt  <= '0;
                r_step_stb <= r_sync2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end

            // Presses arriving while a pulse is active are dropped, not queued.
            if (w_step_accept) begin
                r_step_hi  <= 1'b1;
                r_step_cnt <= STEP_LAST;
            end else if (r_step_hi) begin
                if (r_step_cnt == '0) begin
                    r_step_hi <= 1'b0;
                end else begin
                    r_step_cnt <= r_step_cnt - STEP_W'(1);
                end
            end
        end
    end

    assign o_clkdiv     = r_clkdiv;
    assign o_clk_cpu    = r_clk_cpu;
    assign o_cpu_edge   = r_cpu_edge;
    assign o_cpu_cycles = r_cpu_cycles;
    assign o_mode_cur   = r_mode_cur;
    assign o_switching  = r_switching;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen.
// dut: WIDTH=32, FAST_TAP=2, SLOW_TAP=6, DEB_CYC=4, STEP_HI=3.
// dut8: WIDTH=8, DEB_CYC=1, STEP_HI=8 (counter wrap and press-during-pulse).
module tb_clk_div_gen;

    logic        clk;
    logic        rst_n, rst8_n;
    logic [1:0]  mode, mode8;
    logic        step, step8;
    logic [31:0] clkdiv, cpu_cycles;
    logic        clk_cpu, cpu_edge, switching;
    logic [1:0]  mode_cur;
    logic [7:0]  clkdiv8, cpu_cycles8;
    logic        clk_cpu8, cpu_edge8, switching8;
    logic [1:0]  mode_cur8;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_gen #(
        .WIDTH(32), .FAST_TAP(2), .SLOW_TAP(6), .DEB_CYC(4), .STEP_HI(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_step(step),
        .o_clkdiv(clkdiv), .o_clk_cpu(clk_cpu), .o_cpu_edge(cpu_edge),
        .o_cpu_cycles(cpu_cycles), .o_mode_cur(mode_cur), .o_switching(switching)
    );

    clk_div_gen #(
        .WIDTH(8), .FAST_TAP(2), .SLOW_TAP(6), .DEB_CYC(1), .STEP_HI(8)
    ) dut8 (
        .i_clk(clk), .i_rst_n(rst8_n), .i_mode(mode8), .i_step(step8),
        .o_clkdiv(clkdiv8), .o_clk_cpu(clk_cpu8), .o_cpu_edge(cpu_edge8),
        .o_cpu_cycles(cpu_cycles8), .o_mode_cur(mode_cur8), .o_switching(switching8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] clkdiv;
        logic        clk_cpu;
        logic        cpu_edge;
        logic [31:0] cycles;
        logic [1:0]  mode_cur;
        logic        sw;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " clkdiv"}, clkdiv, 32'd0);
        check({tag, " clk_cpu"}, 32'(clk_cpu), 32'd0);
        check({tag, " cpu_edge"}, 32'(cpu_edge), 32'd0);
        check({tag, " cpu_cycles"}, cpu_cycles, 32'd0);
        check({tag, " mode_cur"}, 32'(mode_cur), 32'd0);
        check({tag, " switching"}, 32'(switching), 32'd0);
    endtask

    initial begin
        int n, hi, bad;
        logic [31:0] cc0, cd0;
        logic found;

        // Cycle-by-cycle expectations after reset release (row i = posedge i+1).
        vecs[0]  = '{2'd0, 32'd1,  1'b0, 1'b0, 32'd0, 2'd0, 1'b0};
        vecs[1]  = '{2'd0, 32'd2,  1'b0, 1'b0, 32'd0, 2'd0, 1'b0};
        vecs[2]  = '{2'd0, 32'd3,  1'b0, 1'b0, 32'd0, 2'd0, 1'b0};
        vecs[3]  = '{2'd0, 32'd4,  1'b0, 1'b0, 32'd0, 2'd0, 1'b0};
        vecs[4]  = '{2'd0, 32'd5,  1'b1, 1'b1, 32'd1, 2'd0, 1'b0};
        vecs[5]  = '{2'd0, 32'd6,  1'b1, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[6]  = '{2'd0, 32'd7,  1'b1, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[7]  = '{2'd0, 32'd8,  1'b1, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[8]  = '{2'd0, 32'd9,  1'b0, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[9]  = '{2'd0, 32'd10, 1'b0, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[10] = '{2'd0, 32'd11, 1'b0, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[11] = '{2'd0, 32'd12, 1'b0, 1'b0, 32'd1, 2'd0, 1'b0};
        vecs[12] = '{2'd0, 32'd13, 1'b1, 1'b1, 32'd2, 2'd0, 1'b0};
        vecs[13] = '{2'd0, 32'd14, 1'b1, 1'b0, 32'd2, 2'd0, 1'b0};
        vecs[14] = '{2'd0, 32'd15, 1'b1, 1'b0, 32'd2, 2'd0, 1'b0};
        vecs[15] = '{2'd0, 32'd16, 1'b1, 1'b0, 32'd2, 2'd0, 1'b0};
        // Request SLOW while clk_cpu is high; completes once clk_cpu and clkdiv[6] are low.
        vecs[16] = '{2'd1, 32'd17, 1'b0, 1'b0, 32'd2, 2'd0, 1'b1};
        vecs[17] = '{2'd1, 32'd18, 1'b0, 1'b0, 32'd2, 2'd1, 1'b0};
        vecs[18] = '{2'd1, 32'd19, 1'b0, 1'b0, 32'd2, 2'd1, 1'b0};

        rst_n  = 1'b1;
        rst8_n = 1'b1;
        mode   = 2'd0;
        mode8  = 2'd0;
        step   = 1'b0;
        step8  = 1'b0;
        #3;
        rst_n  = 1'b0;
        rst8_n = 1'b0;

        // Reset held for 10 clks
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) check_all_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        // FAST startup and first switch, table driven
        for (int i = 0; i < 19; i++) begin
            mode = vecs[i].mode;
            tick();
            check($sformatf("vec%0d clkdiv", i), clkdiv, vecs[i].clkdiv);
            check($sformatf("vec%0d clk_cpu", i), 32'(clk_cpu), 32'(vecs[i].clk_cpu));
            check($sformatf("vec%0d cpu_edge", i), 32'(cpu_edge), 32'(vecs[i].cpu_edge));
            check($sformatf("vec%0d cpu_cycles", i), cpu_cycles, vecs[i].cycles);
            check($sformatf("vec%0d mode_cur", i), 32'(mode_cur), 32'(vecs[i].mode_cur));
            check($sformatf("vec%0d switching", i), 32'(switching), 32'(vecs[i].sw));
        end

        // SLOW: period 128, high 64
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (cpu_edge) found = 1'b1;
        end
        if (!found) timeout("slow first edge");
        check("slow first edge clkdiv", clkdiv, 32'd65);
        cc0 = cpu_cycles;
        n = 0;
        hi = 1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            n++;
            if (cpu_edge) found = 1'b1;
            else if (clk_cpu) hi++;
        end
        if (!found) timeout("slow second edge");
        check("slow period", 32'(n), 32'd128);
        check("slow high phase", 32'(hi), 32'd64);
        check("slow cycles +1", cpu_cycles, cc0 + 32'd1);

        // Pending switch: cancel, then latest request wins
        mode = 2'd0;
        tick();
        check("pend switching", 32'(switching), 32'd1);
        check("pend mode_cur held", 32'(mode_cur), 32'd1);
        mode = 2'd2;
        tick();
        tick();
        check("pend third value switching", 32'(switching), 32'd1);
        check("pend third value clk_cpu", 32'(clk_cpu), 32'd1);
        mode = 2'd1;
        tick();
        check("cancel switching", 32'(switching), 32'd0);
        check("cancel mode_cur", 32'(mode_cur), 32'd1);
        mode = 2'd0;
        tick();
        check("repend switching", 32'(switching), 32'd1);
        mode = 2'd3;
        bad = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (mode_cur == 2'd0) bad++;
            if (!switching) found = 1'b1;
        end
        if (!found) timeout("switch to hold");
        check("stale target never used", 32'(bad), 32'd0);
        check("hold mode_cur", 32'(mode_cur), 32'd3);

        // HOLD: clk_cpu low, cycles frozen, clkdiv counts
        tick();
        cd0 = clkdiv;
        cc0 = cpu_cycles;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk_cpu) hi++;
        end
        check("hold clk_cpu high count", 32'(hi), 32'd0);
        check("hold cycles frozen", cpu_cycles, cc0);
        check("hold clkdiv +100", clkdiv, cd0 + 32'd100);

        // STEP: press held -> single 3-clk pulse
        mode = 2'd2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mode_cur == 2'd2 && !switching) found = 1'b1;
        end
        if (!found) timeout("switch to step");
        tick();
        cc0 = cpu_cycles;
        step = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("step t%0d clk_cpu", i), 32'(clk_cpu), 32'(i >= 7 && i <= 9));
            check($sformatf("step t%0d cpu_edge", i), 32'(cpu_edge), 32'(i == 7));
        end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clk_cpu) hi++;
        end
        check("step held no repeat", 32'(hi), 32'd0);
        check("step cycles +1", cpu_cycles, cc0 + 32'd1);
        step = 1'b0;
        repeat (10) tick();
        // 1-clk glitch
        step = 1'b1;
        tick();
        step = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clk_cpu) hi++;
        end
        check("glitch no pulse", 32'(hi), 32'd0);
        check("glitch cycles", cpu_cycles, cc0 + 32'd1);

        // Asynchronous reset mid step pulse
        step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (clk_cpu) found = 1'b1;
        end
        if (!found) timeout("pulse before reset");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async mid pulse");
        step = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        // Reset mid switch: mode=STEP pending from FAST
        tick();
        check("post reset switching", 32'(switching), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async mid switch");
        tick();
        @(negedge clk);
        mode  = 2'd0;
        rst_n = 1'b1;

        // WIDTH=8 wrap checks
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (clkdiv8 == 8'd255) found = 1'b1;
        end
        if (!found) timeout("clkdiv8 at 255");
        tick();
        check("clkdiv8 wrap", 32'(clkdiv8), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (cpu_cycles8 == 8'd255) found = 1'b1;
        end
        if (!found) timeout("cpu_cycles8 at 255");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (cpu_edge8) found = 1'b1;
        end
        if (!found) timeout("cpu_edge8 after 255");
        check("cpu_cycles8 wrap", 32'(cpu_cycles8), 32'd0);

        // dut8 press arriving during an active pulse is dropped
        mode8 = 2'd2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mode_cur8 == 2'd2 && !switching8) found = 1'b1;
        end
        if (!found) timeout("dut8 switch to step");
        repeat (3) tick();
        cc0 = 32'(cpu_cycles8);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            step8 = (i < 2 || i >= 4);
            tick();
            if (clk_cpu8) hi++;
        end
        check("dut8 pulse length", 32'(hi), 32'd8);
        check("dut8 cycles +1", 32'(cpu_cycles8), 32'((cc0 + 32'd1) & 32'hff));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
